muu_value_get_mc: RTL and testbench

Parametrised successor of the single-width GET value formatter. It takes one lookup response per request (meta, length, opcode, drop flag, user) and emits a framed response stream: one header beat, then value beats of configurable width. The stream gets a byte-keep mask on the final beat and is split into sub-packets after a configurable number of beats. It sits between the hash-table value read path and the response packetiser. Dropped values are drained from memory without being forwarded.

---
 rtl/muu_value_get_mc.sv | 199 +++++++++++++++++++
 tb/tb_muu_value_get_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muu_value_get_mc.sv
// GET value formatter: turns one lookup response into a header beat plus value beats,
// with a final-beat byte mask, sub-packet splitting and silent draining of dropped values.
module muu_value_get_mc #(
    parameter int META_WIDTH          = 96,
    parameter int MEMORY_WIDTH        = 512,
    parameter int USER_BITS           = 3,
    parameter int LEN_BITS            = 10,
    parameter int MAX_BEATS_IN_PACKET = 18
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [META_WIDTH-1:0]              req_meta,
    input  logic [LEN_BITS-1:0]                req_len,
    input  logic [7:0]                         req_op,
    input  logic                               req_drop,
    input  logic [USER_BITS-1:0]               req_user,
    input  logic                               value_valid,
    input  logic [MEMORY_WIDTH-1:0]            value_data,
    output logic                               value_ready,
    output logic                               out_valid,
    output logic [META_WIDTH+MEMORY_WIDTH-1:0] out_data,
    output logic [MEMORY_WIDTH/8-1:0]          out_keep,
    output logic [7:0]                         out_user,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic [31:0]                        stat_req_count,
    output logic [31:0]                        stat_drop_beats
);

    localparam int W      = MEMORY_WIDTH / 64;
    localparam int KEEP_W = MEMORY_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS_IN_PACKET + 1);
    localparam logic [LEN_BITS-1:0] W_L = LEN_BITS'(W);

    typedef enum logic [1:0] {S_IDLE, S_VALUE, S_DROP} state_t;

    state_t                            r_state;
    logic                              r_out_valid;
    logic [META_WIDTH+MEMORY_WIDTH-1:0] r_out_data;
    logic [KEEP_W-1:0]                 r_out_keep;
    logic [7:0]                        r_out_user;
    logic                              r_out_last;
    logic [META_WIDTH-1:0]             r_meta;
    logic [7:0]                        r_user;
    logic [LEN_BITS-1:0]               r_beats_left;
    logic [LEN_BITS-1:0]               r_rem;
    logic [CNT_W-1:0]                  r_since_last;
    logic [31:0]                       r_stat_req;
    logic [31:0]                       r_stat_drop;

    state_t                            w_state_nxt;
    logic                              w_slot_free;
    logic                              w_req_acc;
    logic                              w_val_acc;
    logic [LEN_BITS-1:0]               w_quot;
    logic [LEN_BITS-1:0]               w_rem;
    logic [LEN_BITS-1:0]               w_beats;
    logic [KEEP_W-1:0]                 w_fin_keep;
    logic                              w_load;
    logic [MEMORY_WIDTH-1:0]           w_pay;
    logic [KEEP_W-1:0]                 w_keep;
    logic [META_WIDTH-1:0]             w_meta;
    logic [7:0]                        w_user;
    logic                              w_last_nat;
    logic                              w_split;
    logic                              w_last;

    assign w_slot_free = !r_out_valid || out_ready;
    // Gated by rst_n so every output reads 0 while reset is held.
    assign req_ready   = rst_n && (r_state == S_IDLE) && w_slot_free;
    assign w_req_acc   = req_valid && req_ready;

    always_comb begin
        value_ready = 1'b0;
        case (r_state)
            S_VALUE: value_ready = w_slot_free;
            S_DROP:  value_ready = 1'b1;
            default: value_ready = 1'b0;
        endcase
    end
    assign w_val_acc = value_valid && value_ready;

    assign w_quot  = req_len / W_L;
    assign w_rem   = req_len % W_L;
    assign w_beats = w_quot + LEN_BITS'(w_rem != '0);

    always_comb begin
        w_fin_keep = '0;
        for (int i = 0; i < KEEP_W; i++)
            w_fin_keep[i] = (r_rem == '0) || (i < (int'(r_rem) << 3));
    end

    // The beat being loaded closes the sub-packet if it brings the count to the limit.
    assign w_split = (r_since_last == CNT_W'(MAX_BEATS_IN_PACKET - 1));
    assign w_last  = w_last_nat || w_split;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pay       = '0;
        w_keep      = '0;
        w_meta      = r_meta;
        w_user      = r_user;
        w_last_nat  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_acc) begin
                    w_load                = 1'b1;
                    w_meta                = req_meta;
                    w_user                = 8'(req_user);
                    w_pay[15:0]           = 16'hFFFF;
                    w_pay[23:16]          = req_op;
                    w_pay[32 +: LEN_BITS] = req_drop ? '0 : w_beats;
                    w_keep[7:0]           = 8'hFF;
                    if (w_beats == '0) begin
                        w_last_nat = 1'b1;
                    end else if (req_drop) begin
                        w_last_nat  = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_state_nxt = S_VALUE;
                    end
                end
            end
            S_VALUE: begin
                if (w_val_acc) begin
                    w_load = 1'b1;
                    w_pay  = value_data;
                    w_keep = '1;
                    if (r_beats_left == LEN_BITS'(1)) begin
                        w_keep      = w_fin_keep;
                        w_last_nat  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (w_val_acc && r_beats_left == LEN_BITS'(1))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_user   <= '0;
            r_out_last   <= 1'b0;
            r_meta       <= '0;
            r_user       <= '0;
            r_beats_left <= '0;
            r_rem        <= '0;
            r_since_last <= '0;
            r_stat_req   <= '0;
            r_stat_drop  <= '0;
        end else begin
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= {w_meta, w_pay};
                r_out_keep   <= w_keep;
                r_out_user   <= w_user;
                r_out_last   <= w_last;
                r_since_last <= w_last ? '0 : r_since_last + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_req_acc) begin
                r_meta       <= req_meta;
                r_user       <= 8'(req_user);
                r_beats_left <= w_beats;
                r_rem        <= w_rem;
                r_stat_req   <= r_stat_req + 32'd1;
            end
            if (w_val_acc) begin
                r_beats_left <= r_beats_left - LEN_BITS'(1);
                if (r_state == S_DROP) r_stat_drop <= r_stat_drop + 32'd1;
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign out_keep        = r_out_keep;
    assign out_user        = r_out_user;
    assign out_last        = r_out_last;
    assign stat_req_count  = r_stat_req;
    assign stat_drop_beats = r_stat_drop;

endmodule

// File: tb/tb_muu_value_get_mc.sv
// Directed bench for muu_value_get_mc (512-bit beats, sub-packet limit 4).
module tb_muu_value_get_mc;
    localparam int MW = 512, MTW = 96, UB = 3, LB = 10, MAXB = 4, KW = MW / 8;

    typedef struct {
        logic [MTW+MW-1:0] data;
        logic [KW-1:0]     keep;
        logic [7:0]        user;
        logic              last;
    } beat_t;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              req_valid = 1'b0, req_ready, req_drop = 1'b0;
    logic [MTW-1:0]    req_meta = '0;
    logic [LB-1:0]     req_len = '0;
    logic [7:0]        req_op = '0;
    logic [UB-1:0]     req_user = '0;
    logic              value_valid = 1'b0, value_ready;
    logic [MW-1:0]     value_data;
    logic              out_valid, out_last, out_ready = 1'b1;
    logic [MTW+MW-1:0] out_data;
    logic [KW-1:0]     out_keep;
    logic [7:0]        out_user;
    logic [31:0]       stat_req_count, stat_drop_beats;

    int    n_chk = 0, n_fail = 0, vcons = 0, n_acc = 0;
    beat_t q[$];
    beat_t snap;
    logic  s_valid, s_ready;

    muu_value_get_mc #(.META_WIDTH(MTW), .MEMORY_WIDTH(MW), .USER_BITS(UB), .LEN_BITS(LB),
                       .MAX_BEATS_IN_PACKET(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_meta(req_meta), .req_len(req_len), .req_op(req_op), .req_drop(req_drop),
        .req_user(req_user), .value_valid(value_valid), .value_data(value_data),
        .value_ready(value_ready), .out_valid(out_valid), .out_data(out_data),
        .out_keep(out_keep), .out_user(out_user), .out_last(out_last), .out_ready(out_ready),
        .stat_req_count(stat_req_count), .stat_drop_beats(stat_drop_beats));

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] vpat(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + {16'h0, n[15:0]};
        return {16{w}};
    endfunction

    function automatic logic [MW-1:0] hdr(input logic [7:0] op, input logic [LB-1:0] b);
        logic [MW-1:0] h;
        h = '0;
        h[15:0] = 16'hFFFF;
        h[23:16] = op;
        h[32 +: LB] = b;
        return h;
    endfunction

    // One clock: sample handshakes at the falling edge, update stimulus just after the rising edge.
    task automatic step();
        logic acc, vc;
        @(negedge clk);
        acc = req_valid && req_ready;
        vc  = value_valid && value_ready;
        s_valid = out_valid;
        s_ready = out_ready;
        snap.data = out_data; snap.keep = out_keep; snap.user = out_user; snap.last = out_last;
        if (out_valid && out_ready) q.push_back(snap);
        if (vc) vcons++;
        if (acc) n_acc++;
        @(posedge clk); #1;
        if (acc) req_valid = 1'b0;
        if (vc) value_data = vpat(vcons);
    endtask

    task automatic issue(input logic [MTW-1:0] m, input logic [LB-1:0] len, input logic [7:0] op,
                         input logic drop, input logic [UB-1:0] u);
        req_meta = m; req_len = len; req_op = op; req_drop = drop; req_user = u; req_valid = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: valid=%b last=%b", out_valid, out_last); end
        n_chk++; if (req_ready !== 1'b0 || value_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: req_ready=%b value_ready=%b exp 0 0", req_ready, value_ready); end
        n_chk++; if (stat_req_count !== 32'd0 || stat_drop_beats !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats: %0d %0d exp 0 0", stat_req_count, stat_drop_beats); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: req_ready=%b exp 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [MTW-1:0] m = 96'h1111_2222_3333_4444_5555_6666;
        int base;
        logic [MTW+MW-1:0] ed;
        logic [KW-1:0] ek;
        q.delete(); base = vcons; out_ready = 1'b1; value_valid = 1'b1;
        issue(m, 10'd20, 8'h05, 1'b0, 3'd3);
        repeat (12) step();
        value_valid = 1'b0;
        n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL basic_count: %0d beats exp 4", q.size()); end
        for (int k = 0; k < 4; k++) begin
            ed = (k == 0) ? {m, hdr(8'h05, 10'd3)} : {m, vpat(base + k - 1)};
            ek = (k == 0) ? 64'hFF : (k == 3) ? 64'h0000_0000_FFFF_FFFF : '1;
            n_chk++; if (q[k].data !== ed) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", k, q[k].data[63:0], ed[63:0]); end
            n_chk++; if (q[k].keep !== ek || q[k].last !== (k == 3) || q[k].user !== 8'd3) begin
                n_fail++; $display("FAIL basic_ctl[%0d]: keep=%h last=%b user=%0d exp keep=%h last=%b user=3",
                                   k, q[k].keep, q[k].last, q[k].user, ek, (k == 3)); end
        end
        n_chk++; if (vcons - base != 3 || stat_req_count !== 32'd1) begin
            n_fail++; $display("FAIL basic_stats: consumed=%0d req=%0d exp 3 1", vcons - base, stat_req_count); end
    endtask

    task automatic test_back_to_back();
        int base, acc0;
        q.delete(); base = vcons; acc0 = n_acc; value_valid = 1'b1; out_ready = 1'b1;
        issue(96'hAA, 10'd0, 8'h11, 1'b0, 3'd1);
        step();
        issue(96'hBB, 10'd0, 8'h22, 1'b0, 3'd2);
        step();
        n_chk++; if (n_acc - acc0 != 2) begin
            n_fail++; $display("FAIL b2b_accept: %0d accepts in 2 cycles exp 2", n_acc - acc0); end
        repeat (4) step();
        value_valid = 1'b0;
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL b2b_count: %0d beats exp 2", q.size()); end
        n_chk++; if (q[0].data !== {96'hAA, hdr(8'h11, 10'd0)} || q[0].last !== 1'b1) begin
            n_fail++; $display("FAIL b2b_hdr0: got %h last=%b", q[0].data[63:0], q[0].last); end
        n_chk++; if (q[1].data !== {96'hBB, hdr(8'h22, 10'd0)} || q[1].last !== 1'b1 || q[1].user !== 8'd2) begin
            n_fail++; $display("FAIL b2b_hdr1: got %h last=%b user=%0d", q[1].data[63:0], q[1].last, q[1].user); end
        n_chk++; if (vcons != base || stat_req_count !== 32'd3) begin
            n_fail++; $display("FAIL b2b_noval: consumed=%0d req=%0d exp 0 3", vcons - base, stat_req_count); end
    endtask

    task automatic test_drop();
        int base;
        q.delete(); base = vcons; value_valid = 1'b1; out_ready = 1'b1;
        issue(96'hCC, 10'd16, 8'h33, 1'b1, 3'd4);
        repeat (8) step();
        value_valid = 1'b0;
        n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL drop_count: %0d beats exp 1", q.size()); end
        n_chk++; if (q[0].data !== {96'hCC, hdr(8'h33, 10'd0)} || q[0].last !== 1'b1 || q[0].keep !== 64'hFF) begin
            n_fail++; $display("FAIL drop_hdr: got %h last=%b keep=%h", q[0].data[63:0], q[0].last, q[0].keep); end
        n_chk++; if (vcons - base != 2 || stat_drop_beats !== 32'd2) begin
            n_fail++; $display("FAIL drop_stats: consumed=%0d drop=%0d exp 2 2", vcons - base, stat_drop_beats); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL drop_idle: req_ready=%b exp 1", req_ready); end
    endtask

    task automatic test_split();
        logic [MTW-1:0] m = 96'hDEAD_BEEF_0000_1234_5678_9ABC;
        int base;
        logic el;
        q.delete(); base = vcons; value_valid = 1'b1; out_ready = 1'b1;
        issue(m, 10'd64, 8'h44, 1'b0, 3'd5);
        repeat (14) step();
        value_valid = 1'b0;
        n_chk++; if (q.size() != 9) begin n_fail++; $display("FAIL split_count: %0d beats exp 9", q.size()); end
        n_chk++; if (q[0].data[MW-1:0] !== hdr(8'h44, 10'd8)) begin
            n_fail++; $display("FAIL split_hdr: got %h exp %h", q[0].data[63:0], hdr(8'h44, 10'd8)); end
        for (int k = 0; k < 9; k++) begin
            el = (k == 3) || (k == 7) || (k == 8);
            n_chk++; if (q[k].last !== el || q[k].data[MW +: MTW] !== m || q[k].user !== 8'd5) begin
                n_fail++; $display("FAIL split_beat[%0d]: last=%b exp %b user=%0d", k, q[k].last, el, q[k].user); end
        end
        n_chk++; if (q[8].data[MW-1:0] !== vpat(base + 7) || q[8].keep !== {KW{1'b1}}) begin
            n_fail++; $display("FAIL split_final: got %h keep=%h", q[8].data[63:0], q[8].keep); end
    endtask

    task automatic test_stall();
        logic [MTW-1:0] m = 96'h5A5A;
        int base;
        logic el;
        q.delete(); base = vcons;
        issue(m, 10'd40, 8'h55, 1'b0, 3'd6);
        for (int i = 0; i < 60; i++) begin
            out_ready   = i[0];
            value_valid = (i % 3 != 2);
            step();
            if (s_valid && !s_ready) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== snap.data || out_keep !== snap.keep || out_last !== snap.last) begin
                    n_fail++; $display("FAIL stall_hold[%0d]: valid=%b data %h exp %h", i, out_valid,
                                       out_data[63:0], snap.data[63:0]); end
            end
        end
        out_ready = 1'b1; value_valid = 1'b0;
        n_chk++; if (q.size() != 6 || vcons - base != 5) begin
            n_fail++; $display("FAIL stall_count: %0d beats %0d consumed exp 6 5", q.size(), vcons - base); end
        for (int k = 1; k < 6; k++) begin
            el = (k == 3) || (k == 5);
            n_chk++; if (q[k].data !== {m, vpat(base + k - 1)} || q[k].last !== el) begin
                n_fail++; $display("FAIL stall_beat[%0d]: got %h last=%b exp %h last=%b", k, q[k].data[63:0],
                                   q[k].last, vpat(base + k - 1), el); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        q.delete(); out_ready = 1'b1; value_valid = 1'b0;
        issue(96'h77, 10'd64, 8'h66, 1'b0, 3'd7);
        step();
        out_ready = 1'b0; value_valid = 1'b1;
        step();
        rst_n = 1'b0; #1;
        n_chk++; if (out_valid !== 1'b0 || out_data !== '0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_out: valid=%b req_ready=%b exp 0 0", out_valid, req_ready); end
        n_chk++; if (stat_req_count !== 32'd0 || stat_drop_beats !== 32'd0) begin
            n_fail++; $display("FAIL midrst_stats: %0d %0d exp 0 0", stat_req_count, stat_drop_beats); end
        value_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: req_ready=%b valid=%b exp 1 0", req_ready, out_valid); end
        q.delete(); base = vcons; value_valid = 1'b1;
        issue(96'h88, 10'd8, 8'h67, 1'b0, 3'd2);
        repeat (6) step();
        value_valid = 1'b0;
        n_chk++; if (q.size() != 2 || q[0].data !== {96'h88, hdr(8'h67, 10'd1)} || q[0].last !== 1'b0) begin
            n_fail++; $display("FAIL midrst_hdr: %0d beats hdr %h last=%b", q.size(), q[0].data[63:0], q[0].last); end
        n_chk++; if (q[1].data !== {96'h88, vpat(base)} || q[1].last !== 1'b1 || stat_req_count !== 32'd1) begin
            n_fail++; $display("FAIL midrst_val: got %h last=%b req=%0d", q[1].data[63:0], q[1].last, stat_req_count); end
    endtask

    initial begin
        value_data = vpat(0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_split();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
